// File: rtl/frame_buffer_writer_if.sv
// Pixel-port and memory-write-port bundle for frame_buffer_writer.
// Pixel side: frame_rd_en/frame_x/frame_y/px_color strobes, raster_done, frame_ready.
// Memory side: mem_addr/mem_wdata/mem_we with mem_grant; plus vsync, bank status and err_drop.
interface frame_buffer_writer_if;
  // rasterizer -> writer
  logic        frame_rd_en;
  logic [9:0]  frame_x;
  logic [8:0]  frame_y;
  logic [2:0]  px_color;
  logic        raster_done;
  logic        frame_ready;
  // display timing / bank status
  logic        vsync;
  logic        disp_bank;
  logic        draw_bank;
  logic        swap_pulse;
  // pixel memory write port
  logic [19:0] mem_addr;
  logic [2:0]  mem_wdata;
  logic        mem_we;
  logic        mem_grant;
  // status
  logic        err_drop;

  // The frame buffer writer itself.
  modport slave (
    input  frame_rd_en, frame_x, frame_y, px_color, raster_done, vsync, mem_grant,
    output frame_ready, disp_bank, draw_bank, swap_pulse, mem_addr, mem_wdata, mem_we, err_drop
  );

  // The surrounding environment: rasterizer, display timing and memory.
  modport master (
    output frame_rd_en, frame_x, frame_y, px_color, raster_done, vsync, mem_grant,
    input  frame_ready, disp_bank, draw_bank, swap_pulse, mem_addr, mem_wdata, mem_we, err_drop
  );
endinterface

// File: rtl/frame_buffer_writer.sv
// Purpose: buffer rasterizer pixel strobes, map (x,y) to a ping-pong bank address, write pixel memory.
// Latency: strobe in cycle N -> mem_we at N+2 earliest; one pixel per cycle with mem_grant held high.
// Backpressure: frame_ready (registered) needs >=2 free FIFO slots; mem_grant low stalls the output register.
// Ports: clk, rst (async active-low), bus (frame_buffer_writer_if.slave: pixel port, vsync, bank
// status, memory write port, err_drop).

// Generic synchronous FIFO with occupancy count; simultaneous push/pop while full is allowed.
module fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

module frame_buffer_writer #(
  parameter int FIFO_DEPTH = 8,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int BANK_SIZE  = 307200
) (
  input logic                  clk,
  input logic                  rst,
  frame_buffer_writer_if.slave bus
);
  localparam logic [1:0] ST_DRAW       = 2'd0;
  localparam logic [1:0] ST_DRAIN      = 2'd1;
  localparam logic [1:0] ST_WAIT_VSYNC = 2'd2;

  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int          DW        = 23;
  localparam logic [9:0]  X_LIM     = 10'(H_RES);
  localparam logic [8:0]  Y_LIM     = 9'(V_RES);
  localparam logic [19:0] BANK_OFF  = 20'(BANK_SIZE);
  // Ready needs two free slots: one for the strobe already in flight when ready drops.
  localparam logic [CW-1:0] READY_MAX = CW'(FIFO_DEPTH - 2);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          draw_bank;
  logic          disp_bank;
  logic          swap_pulse;
  logic          frame_ready;
  logic          err_drop;
  logic [19:0]   mem_addr;
  logic [2:0]    mem_wdata;
  logic          mem_we;

  logic          in_range;
  logic [19:0]   pix_addr;
  logic          push;
  logic          pop;
  logic          drop;
  logic [DW-1:0] fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          out_free;

  // y*640 = (y<<9) + (y<<7); all terms zero-extended to 20 bits, max 614399 fits.
  assign pix_addr = (draw_bank ? BANK_OFF : 20'd0)
                  + {2'b00, bus.frame_y, 9'd0}
                  + {4'h0, bus.frame_y, 7'd0}
                  + {10'd0, bus.frame_x};

  assign in_range = (bus.frame_x < X_LIM) && (bus.frame_y < Y_LIM);

  // Output register can take a new word when idle or when its current word retires now.
  assign out_free = !mem_we || bus.mem_grant;
  assign pop      = !fifo_empty && out_free;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push = bus.frame_rd_en && (state == ST_DRAW) && in_range && (!fifo_full || pop);
  assign drop = bus.frame_rd_en && !push;

  fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({pix_addr, bus.px_color}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_DRAW: begin
        if (bus.raster_done) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Done once nothing is queued and the output register is idle or retiring now.
        if (fifo_empty && out_free) state_nxt = ST_WAIT_VSYNC;
      end
      ST_WAIT_VSYNC: begin
        if (bus.vsync) state_nxt = ST_DRAW;
      end
      default: state_nxt = ST_DRAW;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_DRAW;
      draw_bank   <= 1'b0;
      disp_bank   <= 1'b1;
      swap_pulse  <= 1'b0;
      frame_ready <= 1'b0;
      err_drop    <= 1'b0;
    end else begin
      state       <= state_nxt;
      swap_pulse  <= 1'b0;
      if ((state == ST_WAIT_VSYNC) && bus.vsync) begin
        disp_bank  <= draw_bank;
        draw_bank  <= ~draw_bank;
        swap_pulse <= 1'b1;
      end
      // Uses next state so ready reappears with the swap and falls right after raster_done.
      frame_ready <= (state_nxt == ST_DRAW) && (fifo_count <= READY_MAX);
      if (drop) err_drop <= 1'b1;
    end
  end

  // Single holding register in front of the memory; address/data frozen while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (pop) begin
      mem_we    <= 1'b1;
      mem_addr  <= fifo_rdata[DW-1:3];
      mem_wdata <= fifo_rdata[2:0];
    end else if (mem_we && bus.mem_grant) begin
      mem_we    <= 1'b0;
    end
  end

  assign bus.frame_ready = frame_ready;
  assign bus.disp_bank   = disp_bank;
  assign bus.draw_bank   = draw_bank;
  assign bus.swap_pulse  = swap_pulse;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;
  assign bus.mem_we      = mem_we;
  assign bus.err_drop    = err_drop;
endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench for frame_buffer_writer: addressing, backpressure, drops, bank swap,
// early vsync and reset mid-operation. Inputs change and outputs are sampled on the
// falling clock edge, away from the active rising edge.
module tb_frame_buffer_writer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   issued;
  int   writes;
  bit   fell;
  int   exp_addr[$];
  int   exp_col[$];

  frame_buffer_writer_if bus();

  frame_buffer_writer #(
    .FIFO_DEPTH (8),
    .H_RES      (640),
    .V_RES      (480),
    .BANK_SIZE  (307200)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic px(input int x, input int y, input int c);
    bus.frame_rd_en = 1'b1;
    bus.frame_x     = 10'(x);
    bus.frame_y     = 9'(y);
    bus.px_color    = 3'(c);
  endtask

  task automatic idle();
    bus.frame_rd_en = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_frame_ready"}, bus.frame_ready, 0);
    chk({tag, "_mem_we"},      bus.mem_we,      0);
    chk({tag, "_mem_addr"},    bus.mem_addr,    0);
    chk({tag, "_mem_wdata"},   bus.mem_wdata,   0);
    chk({tag, "_draw_bank"},   bus.draw_bank,   0);
    chk({tag, "_disp_bank"},   bus.disp_bank,   1);
    chk({tag, "_swap_pulse"},  bus.swap_pulse,  0);
    chk({tag, "_err_drop"},    bus.err_drop,    0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.frame_rd_en = 1'b0;
    bus.frame_x     = '0;
    bus.frame_y     = '0;
    bus.px_color    = '0;
    bus.raster_done = 1'b0;
    bus.vsync       = 1'b0;
    bus.mem_grant   = 1'b0;

    // ---- reset state and first ready
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b1;
    @(negedge clk);
    chk("first_ready", bus.frame_ready, 1);

    // ---- addressing: (5,2) -> 2*640+5 = 1285, written in N+2
    bus.mem_grant = 1'b1;
    px(5, 2, 3);
    @(negedge clk);
    idle();
    chk("addr_we_n1", bus.mem_we, 0);
    @(negedge clk);
    chk("addr_we_n2", bus.mem_we, 1);
    chk("addr_mem_addr", bus.mem_addr, 1285);
    chk("addr_mem_wdata", bus.mem_wdata, 3);
    chk("addr_err_drop", bus.err_drop, 0);
    @(negedge clk);
    chk("addr_we_retired", bus.mem_we, 0);

    // ---- backpressure: grant held low, strobe while ready
    bus.mem_grant = 1'b0;
    issued = 0;
    fell = 1'b0;
    for (int i = 0; i < 20 && !fell; i++) begin
      if (bus.frame_ready) begin
        px(i, 1, i % 8);
        exp_addr.push_back(640 + i);
        exp_col.push_back(i % 8);
        issued++;
      end else begin
        idle();
        fell = 1'b1;
      end
      @(negedge clk);
    end
    chk("bp_ready_fell", fell, 1);
    chk("bp_stall_we", bus.mem_we, 1);
    chk("bp_stall_addr", bus.mem_addr, 640);
    repeat (2) @(negedge clk);
    chk("bp_stall_addr_hold", bus.mem_addr, 640);
    chk("bp_stall_wdata_hold", bus.mem_wdata, 0);
    bus.mem_grant = 1'b1;
    writes = 0;
    for (int i = 0; i < 40 && writes < issued; i++) begin
      if (bus.mem_we) begin
        chk("bp_write_addr", bus.mem_addr, 32'(exp_addr[writes]));
        chk("bp_write_col", bus.mem_wdata, 32'(exp_col[writes]));
        writes++;
      end
      @(negedge clk);
    end
    chk("bp_write_count", writes, issued);
    chk("bp_we_idle", bus.mem_we, 0);
    chk("bp_no_drop", bus.err_drop, 0);

    // ---- drops: x out of range, then y out of range after fresh reset
    px(640, 0, 1);
    @(negedge clk);
    idle();
    repeat (3) begin
      @(negedge clk);
      chk("drop_x_no_write", bus.mem_we, 0);
    end
    chk("drop_x_err", bus.err_drop, 1);
    repeat (4) @(negedge clk);
    chk("drop_x_err_sticky", bus.err_drop, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("drop_err_cleared", bus.err_drop, 0);
    rst = 1'b1;
    @(negedge clk);
    px(0, 480, 2);
    @(negedge clk);
    idle();
    repeat (3) begin
      @(negedge clk);
      chk("drop_y_no_write", bus.mem_we, 0);
    end
    chk("drop_y_err", bus.err_drop, 1);

    // ---- frame swap
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.mem_grant = 1'b1;
    px(1, 0, 1);
    @(negedge clk);
    px(2, 0, 2);
    @(negedge clk);
    px(3, 0, 3);
    @(negedge clk);
    idle();
    bus.raster_done = 1'b1;
    @(negedge clk);
    bus.raster_done = 1'b0;
    chk("swap_ready_after_done", bus.frame_ready, 0);
    repeat (8) @(negedge clk);
    chk("swap_not_before_vsync", bus.draw_bank, 0);
    chk("swap_pulse_idle", bus.swap_pulse, 0);
    bus.vsync = 1'b1;
    @(negedge clk);
    bus.vsync = 1'b0;
    chk("swap_pulse", bus.swap_pulse, 1);
    chk("swap_draw_bank", bus.draw_bank, 1);
    chk("swap_disp_bank", bus.disp_bank, 0);
    chk("swap_ready", bus.frame_ready, 1);
    @(negedge clk);
    chk("swap_pulse_one_cycle", bus.swap_pulse, 0);
    px(0, 0, 5);
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("bank1_we", bus.mem_we, 1);
    chk("bank1_addr", bus.mem_addr, 307200);
    chk("bank1_wdata", bus.mem_wdata, 5);
    @(negedge clk);

    // ---- early vsync during drain is ignored
    bus.mem_grant = 1'b0;
    px(1, 0, 6);
    @(negedge clk);
    idle();
    bus.raster_done = 1'b1;
    @(negedge clk);
    bus.raster_done = 1'b0;
    @(negedge clk);
    bus.vsync = 1'b1;
    @(negedge clk);
    bus.vsync = 1'b0;
    chk("early_vsync_no_pulse", bus.swap_pulse, 0);
    chk("early_vsync_draw_bank", bus.draw_bank, 1);
    chk("early_stall_we", bus.mem_we, 1);
    chk("early_stall_addr", bus.mem_addr, 307201);
    bus.mem_grant = 1'b1;
    repeat (3) @(negedge clk);
    chk("early_drained", bus.mem_we, 0);
    bus.vsync = 1'b1;
    @(negedge clk);
    bus.vsync = 1'b0;
    chk("late_vsync_pulse", bus.swap_pulse, 1);
    chk("late_vsync_draw_bank", bus.draw_bank, 0);
    chk("late_vsync_disp_bank", bus.disp_bank, 1);

    // ---- reset mid-operation with the FIFO partly full
    bus.mem_grant = 1'b0;
    for (int i = 0; i < 5; i++) begin
      px(i, 3, i);
      @(negedge clk);
    end
    idle();
    chk("mid_pre_reset_we", bus.mem_we, 1);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals("mid");
    @(negedge clk);
    rst = 1'b1;
    bus.mem_grant = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("mid_no_write_after", bus.mem_we, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
